// File: rtl/irq_pkg.sv
// irq_pkg: shared constants and register offsets for the interrupt controller
package irq_pkg;
    localparam int NUM_IRQ = 4;
    localparam logic [7:0] IO_HI = 8'h10;
    typedef enum logic [2:0] {
        REG_IER   = 3'd0,
        REG_IPR   = 3'd1,
        REG_IMODE = 3'd2,
        REG_ISET  = 3'd3,
        REG_ISTAT = 3'd4
    } reg_off_e;
endpackage

// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: CPU IO bus as seen by the interrupt controller
interface irq_ctrl_if;
    logic [15:0] io_addr;
    logic [7:0]  io_wdata;
    logic        io_we;
    logic        io_re;
    logic [7:0]  io_rdata;
    logic        io_sel;
    modport master(output io_addr, io_wdata, io_we, io_re, input io_rdata, io_sel);
    modport slave(input io_addr, io_wdata, io_we, io_re, output io_rdata, io_sel);
endinterface

// File: rtl/irq_src_cell.sv
// irq_src_cell: one interrupt source - event detect, mode, pending and overrun with set-over-clear priority
module irq_src_cell #(
    parameter logic RESET_MODE = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_event,
    input  logic i_mode_we,
    input  logic i_mode_wd,
    input  logic i_sw_set,
    input  logic i_clr,
    input  logic i_ovr_clr,
    output logic o_mode,
    output logic o_pending,
    output logic o_ovr
);
    logic r_prev, r_mode, r_pending, r_ovr;
    logic w_set;
    assign w_set     = r_mode ? (i_event & ~r_prev) : i_event;
    assign o_mode    = r_mode;
    assign o_pending = r_pending;
    assign o_ovr     = r_ovr;
    // A set (hardware or software) always beats a clear so no event is lost on an acknowledge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prev    <= 1'b0;
            r_mode    <= RESET_MODE;
            r_pending <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            r_prev    <= i_event;
            r_mode    <= i_mode_we ? i_mode_wd : r_mode;
            r_pending <= (w_set | i_sw_set) ? 1'b1 : i_clr ? 1'b0 : r_pending;
            r_ovr     <= (w_set & r_pending & ~i_clr) ? 1'b1 : i_ovr_clr ? 1'b0 : r_ovr;
        end
    end
endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped four-source interrupt controller in the 0x10xx IO window
module irq_ctrl
    import irq_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR  = 8'h20,
    parameter logic [3:0] RESET_MASK = 4'b0000,
    parameter logic [3:0] RESET_MODE = 4'b1111
) (
    input  logic             clk,
    input  logic             reset,
    irq_ctrl_if.slave        bus,
    input  logic [3:0]       i_event_in,
    input  logic [3:0]       i_irq_clr,
    input  logic [3:0]       i_irq_vect,
    output logic [3:0]       o_irq
);
    logic [7:0] w_off;
    logic [2:0] w_reg;
    logic       w_hit, w_wr, w_rd;
    logic [3:0] w_clr, w_sw_set, w_ovr_clr, w_mode, w_pending, w_ovr;
    logic       w_mode_we;
    logic [7:0] w_rmux;
    logic [3:0] r_ier, r_last_vect, r_irq;
    logic [7:0] r_rdata;
    logic       r_sel;
    // Offset arithmetic wraps, so the window check is a single unsigned compare
    assign w_off     = bus.io_addr[7:0] - BASE_ADDR;
    assign w_reg     = w_off[2:0];
    assign w_hit     = (bus.io_addr[15:8] == IO_HI) && (w_off <= 8'd4);
    assign w_wr      = bus.io_we & w_hit;
    assign w_rd      = bus.io_re & w_hit;
    assign w_clr     = i_irq_clr | ({4{w_wr && w_reg == REG_IPR}} & bus.io_wdata[3:0]);
    assign w_sw_set  = {4{w_wr && w_reg == REG_ISET}} & bus.io_wdata[3:0];
    assign w_ovr_clr = {4{w_wr && w_reg == REG_ISTAT}} & bus.io_wdata[7:4];
    assign w_mode_we = w_wr && w_reg == REG_IMODE;
    assign w_rmux    = w_reg == REG_IER   ? {4'h0, r_ier} :
                       w_reg == REG_IPR   ? {4'h0, w_pending} :
                       w_reg == REG_IMODE ? {4'h0, w_mode} :
                       w_reg == REG_ISTAT ? {w_ovr, r_last_vect} : 8'h00;
    assign bus.io_rdata = r_rdata;
    assign bus.io_sel   = r_sel;
    assign o_irq        = r_irq;
    genvar i;
    for (i = 0; i < NUM_IRQ; i++) begin : g_src
        irq_src_cell #(.RESET_MODE(RESET_MODE[i])) u_cell (
            .clk       (clk),
            .reset     (reset),
            .i_event   (i_event_in[i]),
            .i_mode_we (w_mode_we),
            .i_mode_wd (bus.io_wdata[i]),
            .i_sw_set  (w_sw_set[i]),
            .i_clr     (w_clr[i]),
            .i_ovr_clr (w_ovr_clr[i]),
            .o_mode    (w_mode[i]),
            .o_pending (w_pending[i]),
            .o_ovr     (w_ovr[i])
        );
    end
    // Enable, vector capture, masked irq output and the registered read port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ier       <= RESET_MASK;
            r_last_vect <= 4'h0;
            r_irq       <= 4'h0;
            r_rdata     <= 8'h00;
            r_sel       <= 1'b0;
        end else begin
            r_ier       <= (w_wr && w_reg == REG_IER) ? bus.io_wdata[3:0] : r_ier;
            r_last_vect <= (i_irq_vect != 4'h0) ? i_irq_vect : r_last_vect;
            r_irq       <= w_pending & r_ier;
            r_rdata     <= w_rd ? w_rmux : 8'h00;
            r_sel       <= w_rd;
        end
    end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed plus randomized check of irq_ctrl against a behavioural model
module tb_irq_ctrl;
    localparam int BASE = 8'h20;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] ev = 4'h0, clr = 4'h0, vect = 4'h0;
    logic [3:0] irq;
    int         n_chk = 0, n_fail = 0;
    logic [3:0] m_pend, m_ovr, m_ier, m_mode, m_prev, m_lastv, m_irq;
    logic [7:0] m_rdata;
    logic       m_sel;
    irq_ctrl_if bus();
    irq_ctrl #(.BASE_ADDR(8'h20), .RESET_MASK(4'b0000), .RESET_MODE(4'b1111)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .i_event_in (ev),
        .i_irq_clr  (clr),
        .i_irq_vect (vect),
        .o_irq      (irq)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask
    task automatic model_reset();
        m_pend = 0; m_ovr = 0; m_ier = 4'b0000; m_mode = 4'b1111;
        m_prev = 0; m_lastv = 0; m_irq = 0; m_rdata = 0; m_sel = 0;
    endtask
    task automatic model_step();
        int off;
        bit hit, wr;
        logic [3:0] np, no;
        off = int'(bus.io_addr[7:0]) - BASE;
        hit = bus.io_addr[15:8] == 8'h10 && off >= 0 && off <= 4;
        wr  = hit && bus.io_we;
        m_sel = hit && bus.io_re;
        m_rdata = 8'h00;
        if (m_sel) begin
            if (off == 0) m_rdata = {4'h0, m_ier};
            if (off == 1) m_rdata = {4'h0, m_pend};
            if (off == 2) m_rdata = {4'h0, m_mode};
            if (off == 4) m_rdata = {m_ovr, m_lastv};
        end
        m_irq = m_pend & m_ier;
        np = m_pend; no = m_ovr;
        for (int n = 0; n < 4; n++) begin
            bit hw, sw, cl;
            hw = m_mode[n] ? (ev[n] && !m_prev[n]) : ev[n];
            sw = wr && off == 3 && bus.io_wdata[n];
            cl = clr[n] || (wr && off == 1 && bus.io_wdata[n]);
            if (hw || sw) np[n] = 1'b1;
            else if (cl) np[n] = 1'b0;
            if (hw && m_pend[n] && !cl) no[n] = 1'b1;
            else if (wr && off == 4 && bus.io_wdata[4+n]) no[n] = 1'b0;
        end
        m_pend = np; m_ovr = no; m_prev = ev;
        if (wr && off == 0) m_ier = bus.io_wdata[3:0];
        if (wr && off == 2) m_mode = bus.io_wdata[3:0];
        if (vect != 0) m_lastv = vect;
    endtask
    task automatic cyc(input logic [3:0] e, input logic [15:0] a, input logic [7:0] wd,
                       input logic we, input logic re, input logic [3:0] c, input logic [3:0] v);
        ev = e; bus.io_addr = a; bus.io_wdata = wd; bus.io_we = we; bus.io_re = re;
        clr = c; vect = v;
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("irq", {4'h0, irq}, {4'h0, m_irq});
        chk("rdata", bus.io_rdata, m_rdata);
        chk("sel", {7'h0, bus.io_sel}, {7'h0, m_sel});
    endtask
    function automatic logic [15:0] ra(input int off);
        return 16'h1000 + 16'(BASE + off);
    endfunction
    initial begin
        bus.io_addr = 0; bus.io_wdata = 0; bus.io_we = 0; bus.io_re = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_irq", {4'h0, irq}, 8'h00);
        chk("rst_rdata", bus.io_rdata, 8'h00);
        reset = 1'b1;
        cyc(0, ra(0), 0, 0, 1, 0, 0); chk("rst_ier", bus.io_rdata, 8'h00);
        cyc(0, ra(2), 0, 0, 1, 0, 0); chk("rst_imode", bus.io_rdata, 8'h0F);
        cyc(0, ra(1), 0, 0, 1, 0, 0); chk("rst_ipr", bus.io_rdata, 8'h00);
        cyc(0, ra(0), 8'h01, 1, 0, 0, 0);
        cyc(4'h1, 0, 0, 0, 0, 0, 0);
        cyc(0, ra(1), 0, 0, 1, 0, 0); chk("edge_ipr", bus.io_rdata, 8'h01);
        chk("edge_irq", {4'h0, irq}, 8'h01);
        cyc(0, 0, 0, 0, 0, 4'h1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0); chk("ack_irq", {4'h0, irq}, 8'h00);
        cyc(4'h2, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(4'h2, 0, 0, 0, 0, 4'h2, 0);
        cyc(0, ra(1), 0, 0, 1, 0, 0); chk("setwin_ipr", bus.io_rdata, 8'h02);
        cyc(0, ra(4), 0, 0, 1, 0, 0); chk("setwin_ovr", bus.io_rdata, 8'h00);
        cyc(4'h4, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(4'h4, 0, 0, 0, 0, 0, 0);
        cyc(0, ra(4), 0, 0, 1, 0, 0); chk("ovr_set", bus.io_rdata, 8'h40);
        cyc(0, ra(4), 8'h40, 1, 0, 0, 0);
        cyc(0, ra(4), 0, 0, 1, 0, 0); chk("ovr_w1c", bus.io_rdata, 8'h00);
        cyc(0, ra(1), 8'h04, 1, 0, 0, 0);
        cyc(0, ra(1), 0, 0, 1, 0, 0); chk("ipr_w1c", bus.io_rdata, 8'h02);
        cyc(0, ra(2), 8'h07, 1, 0, 0, 0);
        cyc(4'h8, 0, 0, 0, 0, 0, 0);
        cyc(4'h8, 0, 0, 0, 0, 4'h8, 0);
        cyc(4'h8, ra(1), 0, 0, 1, 0, 0); chk("level_repend", bus.io_rdata, 8'h0A);
        cyc(0, 0, 0, 0, 0, 4'h8, 0);
        cyc(0, ra(1), 0, 0, 1, 0, 0); chk("level_clr", bus.io_rdata, 8'h02);
        cyc(0, ra(0), 8'h0F, 1, 0, 0, 0);
        cyc(0, ra(3), 8'h0A, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 4'h2);
        cyc(0, ra(4), 0, 0, 1, 0, 0); chk("istat_vect", bus.io_rdata, 8'h82);
        chk("sw_irq", {4'h0, irq}, 8'h0A);
        cyc(0, ra(3), 0, 0, 1, 0, 0); chk("iset_rd0", bus.io_rdata, 8'h00);
        cyc(0, ra(4), 0, 0, 1, 0, 0);
        #2 reset = 1'b0;
        #1;
        chk("async_irq", {4'h0, irq}, 8'h00);
        chk("async_rdata", bus.io_rdata, 8'h00);
        chk("async_sel", {7'h0, bus.io_sel}, 8'h00);
        model_reset();
        @(negedge clk) reset = 1'b1;
        for (int k = 0; k < 600; k++) begin
            logic [15:0] a;
            logic [3:0] e, c;
            a[15:8] = ($urandom_range(0, 7) == 0) ? 8'h11 : 8'h10;
            a[7:0]  = 8'(BASE - 2 + int'($urandom_range(0, 8)));
            e = 4'($urandom) & 4'($urandom);
            c = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            cyc(e, a, 8'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom),
                c, ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
